// File: rtl/vmem_seq_pkg.sv
// rtl/vmem_seq_pkg.sv - shared types and defaults for the vector memory sequencer
// Contents: state encoding, default geometry, lane-index width helper.

package vmem_seq_pkg;

    localparam int DEF_LANES  = 4;
    localparam int DEF_LANE_W = 8;
    localparam int DEF_ADDR_W = 16;

    // A lane counter needs at least one bit even for a single-lane build.
    function automatic int lane_idx_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    localparam int LANE_IDX_W = lane_idx_w(DEF_LANES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/vmem_lane_buffer.sv
// rtl/vmem_lane_buffer.sv - captured store vector with lane mux and load assembly register
// Ports:
//   clk, rst_n    clock, async active-low reset
//   load          capture wdata (start accepted)
//   wdata         full store vector
//   sel           current lane index
//   rd_we         write rd_lane into rdata lane sel
//   rd_lane       lane load data
//   lane_wdata    selected store lane
//   rdata         assembled load vector

module vmem_lane_buffer
    import vmem_seq_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int LANE_W = DEF_LANE_W,
    parameter int IDX_W  = lane_idx_w(DEF_LANES)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [LANES*LANE_W-1:0]   wdata,
    input  logic [IDX_W-1:0]          sel,
    input  logic                      rd_we,
    input  logic [LANE_W-1:0]         rd_lane,
    output logic [LANE_W-1:0]         lane_wdata,
    output logic [LANES*LANE_W-1:0]   rdata
);

    logic [LANES*LANE_W-1:0] store_q;
    logic [LANES*LANE_W-1:0] rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store_q <= '0;
            rdata_q <= '0;
        end else begin
            if (load)
                store_q <= wdata;
            // rdata is only ever touched lane-by-lane, so lanes not reached
            // by an abandoned load keep their previous contents.
            if (rd_we)
                rdata_q[sel*LANE_W +: LANE_W] <= rd_lane;
        end
    end

    assign lane_wdata = store_q[sel*LANE_W +: LANE_W];
    assign rdata      = rdata_q;

endmodule

// File: rtl/vmem_sequencer.sv
// rtl/vmem_sequencer.sv - splits a vector LDR/STR into single-lane req/ack memory accesses
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   start, is_store, base_addr, wdata  instruction from decode (sampled in IDLE)
//   flush                            abandon current access
//   busy, done, reg_we, sp_we        pipeline stall / completion / writeback strobes
//   next_addr, rdata                 post-access address, assembled load vector
//   mem_req, mem_we, mem_addr, mem_wdata, mem_rdata, mem_ack   lane memory handshake

module vmem_sequencer
    import vmem_seq_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int LANE_W = DEF_LANE_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     is_store,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [LANES*LANE_W-1:0]  wdata,
    input  logic                     flush,
    output logic                     busy,
    output logic                     done,
    output logic                     reg_we,
    output logic                     sp_we,
    output logic [ADDR_W-1:0]        next_addr,
    output logic [LANES*LANE_W-1:0]  rdata,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [LANE_W-1:0]        mem_wdata,
    input  logic [LANE_W-1:0]        mem_rdata,
    input  logic                     mem_ack
);

    localparam int IDX_W = lane_idx_w(LANES);

    state_e              state;
    logic [IDX_W-1:0]    lane;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W-1:0]   next_q;
    logic                is_store_q;
    logic                flush_pend;

    logic accept;
    logic lane_ack;
    logic last_lane;

    assign accept    = (state == ST_IDLE) && start && !flush;
    assign lane_ack  = (state == ST_REQ) && mem_ack;
    assign last_lane = (lane == IDX_W'(LANES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            lane       <= '0;
            base_q     <= '0;
            next_q     <= '0;
            is_store_q <= 1'b0;
            flush_pend <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state      <= ST_REQ;
                        lane       <= '0;
                        base_q     <= base_addr;
                        next_q     <= base_addr + ADDR_W'(LANES);
                        is_store_q <= is_store;
                        flush_pend <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        // A flush never breaks an outstanding handshake; it
                        // takes effect once the current lane is acknowledged.
                        if (flush || flush_pend) begin
                            state      <= ST_IDLE;
                            lane       <= '0;
                            flush_pend <= 1'b0;
                        end else if (last_lane) begin
                            state <= ST_DONE;
                        end else begin
                            lane <= lane + 1'b1;
                        end
                    end else if (flush) begin
                        flush_pend <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    lane  <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Handshake outputs decode straight from state so async reset drops
    // mem_req and busy without waiting for a clock edge.
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign reg_we    = done && !is_store_q;
    assign sp_we     = done && is_store_q;
    assign mem_req   = (state == ST_REQ);
    assign mem_we    = mem_req && is_store_q;
    assign mem_addr  = base_q + ADDR_W'(lane);
    assign next_addr = next_q;

    vmem_lane_buffer #(
        .LANES  (LANES),
        .LANE_W (LANE_W),
        .IDX_W  (IDX_W)
    ) u_lane_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (accept),
        .wdata      (wdata),
        .sel        (lane),
        .rd_we      (lane_ack && !is_store_q),
        .rd_lane    (mem_rdata),
        .lane_wdata (mem_wdata),
        .rdata      (rdata)
    );

endmodule

// File: tb/tb_vmem_sequencer.sv
// tb/tb_vmem_sequencer.sv - scoreboard bench for vmem_sequencer

module tb_vmem_sequencer;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [7:0]  wdata;
    } acc_t;

    typedef struct {
        logic [31:0] rdata;
        logic [15:0] next_addr;
        logic        is_store;
    } res_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_store;
    logic [15:0] base_addr;
    logic [31:0] wdata;
    logic        flush;
    logic        busy;
    logic        done;
    logic        reg_we;
    logic        sp_we;
    logic [15:0] next_addr;
    logic [31:0] rdata;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    logic [7:0]  mem [0:65535];
    int          wait_cfg;
    int          wcnt;
    int          checks;
    int          errors;
    int          done_cnt;
    int          regwe_cnt;
    int          spwe_cnt;
    logic [31:0] exp_rdata;
    acc_t        acc_q[$];
    res_t        res_q[$];

    vmem_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_store  (is_store),
        .base_addr (base_addr),
        .wdata     (wdata),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .reg_we    (reg_we),
        .sp_we     (sp_we),
        .next_addr (next_addr),
        .rdata     (rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: ack after wait_cfg idle cycles of an outstanding request.
    assign mem_ack   = mem_req && (wcnt >= wait_cfg);
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_req && !mem_ack)
            wcnt <= wcnt + 1;
        else
            wcnt <= 0;
        if (mem_req && mem_ack && mem_we)
            mem[mem_addr] <= mem_wdata;
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_req) begin
                if (acc_q.size() == 0) begin
                    check_eq("access_expected", 64'(acc_q.size()), 64'd1);
                end else begin
                    check_eq("mem_addr", mem_addr, acc_q[0].addr);
                    check_eq("mem_we", mem_we, acc_q[0].we);
                    if (acc_q[0].we)
                        check_eq("mem_wdata", mem_wdata, acc_q[0].wdata);
                    if (mem_ack)
                        void'(acc_q.pop_front());
                end
            end
            if (done) begin
                done_cnt++;
                if (res_q.size() == 0) begin
                    check_eq("result_expected", 64'(res_q.size()), 64'd1);
                end else begin
                    check_eq("rdata", rdata, res_q[0].rdata);
                    check_eq("next_addr", next_addr, res_q[0].next_addr);
                    check_eq("reg_we", reg_we, !res_q[0].is_store);
                    check_eq("sp_we", sp_we, res_q[0].is_store);
                    void'(res_q.pop_front());
                end
            end
            if (reg_we) regwe_cnt++;
            if (sp_we)  spwe_cnt++;
        end
    end

    task automatic push_acc(input logic st, input logic [15:0] base, input logic [31:0] wd, input int n);
        acc_t a;
        for (int i = 0; i < n; i++) begin
            a.addr  = base + 16'(i);
            a.we    = st;
            a.wdata = wd[i*8 +: 8];
            acc_q.push_back(a);
            if (!st)
                exp_rdata[i*8 +: 8] = mem[a.addr];
        end
    endtask

    task automatic pulse_start(input logic st, input logic [15:0] base, input logic [31:0] wd);
        @(posedge clk); #1;
        start = 1'b1; is_store = st; base_addr = base; wdata = wd;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_op(input logic st, input logic [15:0] base, input logic [31:0] wd,
                          input int wt, input int exp_busy, input logic poke);
        res_t r;
        int   cnt;
        int   d0;
        wait_cfg = wt;
        push_acc(st, base, wd, 4);
        r.rdata = exp_rdata; r.next_addr = base + 16'd4; r.is_store = st;
        res_q.push_back(r);
        d0 = done_cnt;
        pulse_start(st, base, wd);
        cnt = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
            start = poke && (cnt == 2);
            if (start) base_addr = 16'h0999;
        end
        start = 1'b0;
        check_eq("busy_cycles", 64'(cnt), 64'(exp_busy));
        check_eq("done_pulses", 64'(done_cnt - d0), 64'd1);
        check_eq("acc_left", 64'(acc_q.size()), 64'd0);
        check_eq("res_left", 64'(res_q.size()), 64'd0);
    endtask

    initial begin
        int d0;
        int rw0;
        int sw0;
        checks = 0; errors = 0; done_cnt = 0; regwe_cnt = 0; spwe_cnt = 0;
        wait_cfg = 0; wcnt = 0; exp_rdata = '0;
        rst_n = 1'b0; start = 1'b0; is_store = 1'b0; base_addr = '0; wdata = '0; flush = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0010] = 8'h11; mem[16'h0011] = 8'h22; mem[16'h0012] = 8'h33; mem[16'h0013] = 8'h44;
        mem[16'hFFFE] = 8'hA1; mem[16'hFFFF] = 8'hB2; mem[16'h0000] = 8'hC3; mem[16'h0001] = 8'hD4;
        mem[16'h0040] = 8'h05; mem[16'h0041] = 8'h06; mem[16'h0042] = 8'h07; mem[16'h0043] = 8'h08;
        mem[16'h0020] = 8'h9A; mem[16'h0021] = 8'h9B; mem[16'h0022] = 8'h9C; mem[16'h0023] = 8'h9D;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_mem_req", mem_req, 1'b0);
        check_eq("rst_mem_we", mem_we, 1'b0);
        check_eq("rst_mem_addr", mem_addr, 16'h0000);
        check_eq("rst_next_addr", next_addr, 16'h0000);
        check_eq("rst_rdata", rdata, 32'h0);
        rst_n = 1'b1;

        // Zero-wait LDR
        run_op(1'b0, 16'h0010, 32'h0, 0, 5, 1'b0);
        check_eq("ldr_rdata", rdata, 32'h44332211);

        // STR with two wait cycles per lane
        run_op(1'b1, 16'h0100, 32'hDDCCBBAA, 2, 13, 1'b0);
        check_eq("str_mem0", mem[16'h0100], 8'hAA);
        check_eq("str_mem3", mem[16'h0103], 8'hDD);
        check_eq("str_rdata_kept", rdata, 32'h44332211);

        // Address wrap
        run_op(1'b0, 16'hFFFE, 32'h0, 0, 5, 1'b0);
        check_eq("wrap_rdata", rdata, 32'hD4C3B2A1);

        // Flush while lane 1 waits
        wait_cfg = 2;
        push_acc(1'b0, 16'h0040, 32'h0, 2);
        d0 = done_cnt; rw0 = regwe_cnt; sw0 = spwe_cnt;
        pulse_start(1'b0, 16'h0040, 32'h0);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (mem_req && mem_addr == 16'h0041) break;
        end
        check_eq("flush_at_lane1", mem_addr, 16'h0041);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check_eq("flush_hold_req", mem_req, 1'b1);
        for (int k = 0; k < 50; k++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check_eq("flush_idle", busy, 1'b0);
        repeat (4) @(negedge clk);
        check_eq("flush_done", 64'(done_cnt - d0), 64'd0);
        check_eq("flush_reg_we", 64'(regwe_cnt - rw0), 64'd0);
        check_eq("flush_sp_we", 64'(spwe_cnt - sw0), 64'd0);
        check_eq("flush_acc_left", 64'(acc_q.size()), 64'd0);
        check_eq("flush_partial_rdata", rdata, exp_rdata);

        // Flush and start together in IDLE
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; base_addr = 16'h0050; is_store = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("fs_mem_req", mem_req, 1'b0);
            check_eq("fs_busy", busy, 1'b0);
        end

        // Start pulsed while busy is ignored
        run_op(1'b0, 16'h0020, 32'h0, 1, 9, 1'b1);
        check_eq("poke_rdata", rdata, 32'h9D9C9B9A);

        // Async reset in the middle of lane 2
        wait_cfg = 1;
        push_acc(1'b0, 16'h0060, 32'h0, 4);
        pulse_start(1'b0, 16'h0060, 32'h0);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (mem_req && mem_addr == 16'h0062) break;
        end
        check_eq("rst_at_lane2", mem_addr, 16'h0062);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_mem_req", mem_req, 1'b0);
        check_eq("arst_busy", busy, 1'b0);
        check_eq("arst_done", done, 1'b0);
        check_eq("arst_rdata", rdata, 32'h0);
        acc_q.delete();
        res_q.delete();
        exp_rdata = '0;
        @(negedge clk);
        rst_n = 1'b1;
        mem[16'h0000] = 8'h01; mem[16'h0001] = 8'h02; mem[16'h0002] = 8'h03; mem[16'h0003] = 8'h04;
        run_op(1'b0, 16'h0000, 32'h0, 0, 5, 1'b0);
        check_eq("post_rst_rdata", rdata, 32'h04030201);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vmem_sequencer.md
Name: vmem_sequencer

Overview:
- Multi-cycle sequencer for vector LDR/STR issued by the decode stage (memory-class instructions with LDFlag set).
- Splits one LANES-wide vector access into LANES single-lane accesses to the single-port data memory, using a req/ack handshake.
- Stalls the pipeline while active, assembles loaded lanes into one vector for register writeback, and reports the post-access address for the SP update on STR.

Parameters:
- LANES, 4, vector lanes per access.
- LANE_W, 8, bits per lane (memory word width).
- ADDR_W, 16, data memory address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  vector memory instruction valid; sampled only in IDLE.
- is_store  in  1  1 = STR (MemWrite), 0 = LDR; captured at start.
- base_addr  in  ADDR_W  address of lane 0; captured at start.
- wdata  in  LANES*LANE_W  store vector, lane i at bits [i*LANE_W +: LANE_W]; captured at start.
- flush  in  1  abandon the current access (branch/abort).
- busy  out  1  pipeline stall; high whenever state != IDLE.
- done  out  1  one-cycle pulse on successful completion.
- reg_we  out  1  equals done & ~captured is_store (LDR writeback).
- sp_we  out  1  equals done & captured is_store.
- next_addr  out  ADDR_W  base_addr + LANES (mod 2^ADDR_W); valid while done.
- rdata  out  LANES*LANE_W  loaded vector, same lane packing as wdata.
- mem_req  out  1  lane access request.
- mem_we  out  1  lane write enable.
- mem_addr  out  ADDR_W  lane address.
- mem_wdata  out  LANE_W  lane store data.
- mem_rdata  in  LANE_W  lane load data; valid when mem_ack.
- mem_ack  in  1  access complete; may be high in the same cycle as mem_req.

Behaviour:
- Reset (async, rst_n low): state IDLE; busy, done, reg_we, sp_we, mem_req, mem_we = 0; mem_addr, mem_wdata, next_addr, rdata, lane counter = 0. mem_req drops immediately, not at the next edge.
- States:
  - IDLE: start & ~flush at edge -> REQ. Capture base/wdata/is_store, lane = 0.
  - REQ: mem_req = 1. mem_addr = base + lane (mod 2^ADDR_W). mem_we = is_store. mem_wdata = wdata lane[lane].
    - On ack with lane == LANES-1 -> DONE.
    - On ack otherwise -> lane + 1, stay in REQ.
    - With no ack, hold all mem_* outputs stable.
  - DONE: done = 1 for exactly one cycle, then -> IDLE.
- Load capture: on each ack of a load, mem_rdata is written into rdata lane[lane]. rdata holds its value until overwritten by a later load. Stores never modify rdata.
- Latency: start accepted at edge t; mem_req is high from cycle t+1. With zero-wait ack, done is high in cycle t+LANES+1 and busy is high for LANES+1 cycles.
- Wait states: each cycle of ack-low adds one cycle. There is no timeout.
- An ack sampled while mem_req is low is ignored.
- start while busy is ignored; the pipeline is stalled, so no queueing is needed.
- Flush:
  - In IDLE, flush wins over a simultaneous start; nothing is accepted.
  - In REQ with ack in the same cycle: the current lane completes, then -> IDLE with no done, reg_we or sp_we.
  - In REQ without ack: set flush_pending, keep mem_req asserted until ack (the handshake is never dropped), then -> IDLE without done.
  - In DONE: ignored; done still pulses.
- A partially completed load updates only the lanes it reached. Because reg_we stays 0, this is architecturally invisible.
- Address wrap: lane addresses and next_addr wrap modulo 2^ADDR_W.

Decomposition:
- Package vmem_seq_pkg holds:
  - the state enum (IDLE, REQ, DONE, 2-bit);
  - default LANES / LANE_W / ADDR_W localparams;
  - the lane-index width as $clog2(LANES).
- One natural sub-module, vmem_lane_buffer: the captured store vector with lane-select mux, plus the rdata lane-write register.
- The FSM, counter and handshake stay in the top module.

Test Plan:
- Zero-wait LDR: base=0x0010, mem_ack tied high, memory[0x10..0x13] = 11,22,33,44 -> mem_addr 0x10..0x13 on consecutive cycles; done and reg_we high at cycle t+5; rdata = 0x44332211; next_addr = 0x0014; sp_we = 0.
- STR with wait states: wdata = 0xDDCCBBAA, base = 0x0100, ack delayed 2 cycles per lane -> mem_wdata AA,BB,CC,DD with mem_we = 1, each held stable across its wait cycles; busy for 13 cycles; sp_we pulses once; rdata unchanged.
- Address wrap: base = 0xFFFE LDR -> mem_addr sequence FFFE, FFFF, 0000, 0001; next_addr = 0x0002.
- Flush during wait: flush while lane 1 is waiting on ack -> mem_req stays high until ack, then IDLE; no done, reg_we or sp_we; lanes 2 and 3 are never requested.
- Flush vs start and busy start: flush & start together in IDLE -> no mem_req. Start pulsed while in REQ -> ignored; exactly LANES accesses occur.
- Async reset mid-access: rst_n low during lane 2 between clock edges -> mem_req and busy drop immediately; after release, state is IDLE and a new LDR from base 0 completes normally.
